pong_update_sched: RTL and testbench

PONG_UPDATE_SCHED -- requirements
Module: pong_update_sched

---
 rtl/pong_update_sched.sv | 153 +++++++++++++++
 tb/tb_pong_update_sched.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pong_update_sched.sv
// Per-frame update sequencer: left paddle, right paddle, ball, then a collision strobe during vblank.
// Optional per-unit ack timeout is enabled by defining SCHED_TIMEOUT_EN.
module pong_update_sched #(
  parameter logic [9:0] VBLANK_LINE = 10'd480,
  parameter logic [7:0] TIMEOUT     = 8'd200
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_game_en,
  input  logic [9:0] i_hcount,
  input  logic [9:0] i_vcount,
  input  logic [2:0] i_upd_ack,
  input  logic       i_clr_err,
  output logic       o_pix_en,
  output logic [2:0] o_upd_req,
  output logic       o_coll_stb,
  output logic       o_busy,
  output logic [7:0] o_frame_cnt,
  output logic [2:0] o_err,
  output logic       o_overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ_L, S_REQ_R, S_REQ_BALL, S_COLLIDE, S_DONE
  } state_t;

  state_t     r_state;
  logic       r_pix_en;
  logic [2:0] r_upd_req;
  logic       r_coll_stb;
  logic       r_busy;
  logic [7:0] r_frame_cnt;
  logic       r_overrun;
  logic       r_vb_cond;
  logic       r_vtop_cond;

  logic w_vb_cond, w_vtop_cond, w_trig, w_vtop_rise;
  logic w_ack_hit, w_tmo, w_advance, w_ovr_set;

  assign w_vb_cond   = (i_vcount == VBLANK_LINE) && (i_hcount == 10'd0);
  assign w_vtop_cond = (i_vcount == 10'd0) && (i_hcount == 10'd0);
  assign w_trig      = w_vb_cond & ~r_vb_cond;
  assign w_vtop_rise = w_vtop_cond & ~r_vtop_cond;

  // r_upd_req is one-hot for the current REQ state, so it masks out acks from other units.
  assign w_ack_hit = |(i_upd_ack & r_upd_req);
  assign w_advance = w_ack_hit | w_tmo;
  assign w_ovr_set = r_busy & (w_trig | w_vtop_rise);

`ifdef SCHED_TIMEOUT_EN
  logic [7:0] r_wait;
  logic [2:0] r_err;
  assign w_tmo = (r_upd_req != 3'b000) && (r_wait == TIMEOUT - 8'd1);
  assign o_err = r_err;
`else
  assign w_tmo = 1'b0;
  assign o_err = 3'b000;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_pix_en    <= 1'b0;
      r_upd_req   <= 3'b000;
      r_coll_stb  <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= 8'd0;
      r_overrun   <= 1'b0;
      r_vb_cond   <= 1'b0;
      r_vtop_cond <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      r_wait      <= 8'd0;
      r_err       <= 3'b000;
`endif
    end else begin
      r_pix_en    <= ~r_pix_en;
      r_vb_cond   <= w_vb_cond;
      r_vtop_cond <= w_vtop_cond;

      // Set beats clear when both happen in the same cycle.
      if (w_ovr_set)
        r_overrun <= 1'b1;
      else if (i_clr_err)
        r_overrun <= 1'b0;

`ifdef SCHED_TIMEOUT_EN
      r_err  <= (i_clr_err ? 3'b000 : r_err) | ({3{w_tmo & ~w_ack_hit}} & r_upd_req);
      r_wait <= r_wait + 8'd1;
`endif

      case (r_state)
        S_IDLE: begin
          if (w_trig && i_game_en) begin
            r_state   <= S_REQ_L;
            r_upd_req <= 3'b001;
            r_busy    <= 1'b1;
`ifdef SCHED_TIMEOUT_EN
            r_wait    <= 8'd0;
`endif
          end
        end
        S_REQ_L: begin
          if (w_advance) begin
            r_state   <= S_REQ_R;
            r_upd_req <= 3'b010;
`ifdef SCHED_TIMEOUT_EN
            r_wait    <= 8'd0;
`endif
          end
        end
        S_REQ_R: begin
          if (w_advance) begin
            r_state   <= S_REQ_BALL;
            r_upd_req <= 3'b100;
`ifdef SCHED_TIMEOUT_EN
            r_wait    <= 8'd0;
`endif
          end
        end
        S_REQ_BALL: begin
          if (w_advance) begin
            r_state    <= S_COLLIDE;
            r_upd_req  <= 3'b000;
            r_coll_stb <= 1'b1;
          end
        end
        S_COLLIDE: begin
          r_state    <= S_DONE;
          r_coll_stb <= 1'b0;
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_frame_cnt <= r_frame_cnt + 8'd1;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_upd_req  <= 3'b000;
          r_coll_stb <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign o_pix_en    = r_pix_en;
  assign o_upd_req   = r_upd_req;
  assign o_coll_stb  = r_coll_stb;
  assign o_busy      = r_busy;
  assign o_frame_cnt = r_frame_cnt;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_pong_update_sched.sv
// Directed bench for pong_update_sched: sequencing, gating, overrun, wrap, async reset
// and (when SCHED_TIMEOUT_EN is defined) the ack timeout.
module tb_pong_update_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       game_en;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic [2:0] upd_ack;
  logic       clr_err;
  logic       pix_en;
  logic [2:0] upd_req;
  logic       coll_stb;
  logic       busy;
  logic [7:0] frame_cnt;
  logic [2:0] err;
  logic       overrun;

  int         num_vec = 0;
  int         num_err = 0;
  logic [7:0] exp_fc  = 8'd0;
  logic [2:0] seq [0:7];
  int         seq_n;
  int         coll_n;
  int         cnt [3];
  int         req_cyc [3];
  logic [2:0] prev_req;

  always #5 clk = ~clk;

  pong_update_sched dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_game_en  (game_en),
    .i_hcount   (hcount),
    .i_vcount   (vcount),
    .i_upd_ack  (upd_ack),
    .i_clr_err  (clr_err),
    .o_pix_en   (pix_en),
    .o_upd_req  (upd_req),
    .o_coll_stb (coll_stb),
    .o_busy     (busy),
    .o_frame_cnt(frame_cnt),
    .o_err      (err),
    .o_overrun  (overrun)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // Present a rising vblank-start condition for one cycle and reset the observation log.
  task automatic start_frame();
    seq_n = 0; coll_n = 0; prev_req = 3'b000;
    for (int b = 0; b < 3; b++) begin cnt[b] = 0; req_cyc[b] = 0; end
    vcount = 10'd480; hcount = 10'd0;
    tick();
    hcount = 10'd1;
  endtask

  // Model the three update units: each acks two cycles into its request if enabled.
  task automatic service(input logic [2:0] en, input int budget, input bit stop_idle);
    for (int i = 0; i < budget; i++) begin
      if (upd_req != prev_req && upd_req != 3'b000 && seq_n < 8) begin
        seq[seq_n] = upd_req; seq_n++;
      end
      prev_req = upd_req;
      if (coll_stb) coll_n++;
      for (int b = 0; b < 3; b++) begin
        if (upd_req[b]) begin cnt[b]++; req_cyc[b]++; end else cnt[b] = 0;
        upd_ack[b] = en[b] && upd_req[b] && (cnt[b] >= 2);
      end
      if (stop_idle && !busy) break;
      tick();
    end
    upd_ack = 3'b000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; game_en = 1'b1; hcount = 10'd1; vcount = 10'd0;
    upd_ack = 3'b000; clr_err = 1'b0;
    tick(); tick();
    num_vec++; if ({pix_en, upd_req, coll_stb, busy, frame_cnt, err, overrun} !== 17'd0) begin
      $display("FAIL reset_outputs: got %h expected 0", {pix_en, upd_req, coll_stb, busy, frame_cnt, err, overrun}); num_err++; end
    rst_n = 1'b1;
    tick();
    num_vec++; if (pix_en !== 1'b1) begin $display("FAIL pix_first: got %b expected 1", pix_en); num_err++; end
    tick();
    num_vec++; if (pix_en !== 1'b0) begin $display("FAIL pix_toggle: got %b expected 0", pix_en); num_err++; end
    $display("reset: pix_en after release 1 then 0 checked");
  endtask

  task automatic test_basic_frame();
    start_frame();
    service(3'b111, 40, 1'b1);
    exp_fc = exp_fc + 8'd1;
    num_vec++; if (busy !== 1'b0) begin $display("FAIL basic_done: busy %b expected 0 within budget", busy); num_err++; end
    num_vec++; if (seq_n !== 3) begin $display("FAIL basic_seq_len: got %0d expected 3", seq_n); num_err++; end
    num_vec++; if (seq[0] !== 3'b001) begin $display("FAIL basic_seq0: got %b expected 001", seq[0]); num_err++; end
    num_vec++; if (seq[1] !== 3'b010) begin $display("FAIL basic_seq1: got %b expected 010", seq[1]); num_err++; end
    num_vec++; if (seq[2] !== 3'b100) begin $display("FAIL basic_seq2: got %b expected 100", seq[2]); num_err++; end
    num_vec++; if (coll_n !== 1) begin $display("FAIL basic_coll: got %0d pulses expected 1", coll_n); num_err++; end
    num_vec++; if (req_cyc[1] !== 2) begin $display("FAIL basic_req_len: got %0d expected 2", req_cyc[1]); num_err++; end
    num_vec++; if (frame_cnt !== 8'd1) begin $display("FAIL basic_fcnt: got %0d expected 1", frame_cnt); num_err++; end
    $display("basic frame: seq_n=%0d coll=%0d frame_cnt=%0d", seq_n, coll_n, frame_cnt);
  endtask

  task automatic test_ignored_ack();
    start_frame();
    upd_ack = 3'b110;
    tick(); tick(); tick();
    num_vec++; if (upd_req !== 3'b001) begin $display("FAIL stray_ack: upd_req %b expected 001", upd_req); num_err++; end
    upd_ack = 3'b000;
    service(3'b111, 40, 1'b1);
    exp_fc = exp_fc + 8'd1;
    num_vec++; if (frame_cnt !== exp_fc) begin $display("FAIL stray_fcnt: got %0d expected %0d", frame_cnt, exp_fc); num_err++; end
    $display("stray acks during REQ_L: upd_req held, frame_cnt=%0d", frame_cnt);
  endtask

  task automatic test_game_disabled();
    game_en = 1'b0;
    for (int f = 0; f < 3; f++) begin
      start_frame();
      service(3'b111, 10, 1'b0);
      vcount = 10'd0; hcount = 10'd0; tick(); hcount = 10'd1;
      num_vec++; if (seq_n !== 0) begin $display("FAIL dis_req f%0d: %0d requests expected 0", f, seq_n); num_err++; end
      num_vec++; if (frame_cnt !== exp_fc) begin $display("FAIL dis_fcnt f%0d: got %0d expected %0d", f, frame_cnt, exp_fc); num_err++; end
      num_vec++; if (overrun !== 1'b0) begin $display("FAIL dis_ovr f%0d: got %b expected 0", f, overrun); num_err++; end
      $display("disabled frame %0d: requests=%0d frame_cnt=%0d overrun=%b", f, seq_n, frame_cnt, overrun);
    end
    game_en = 1'b1;
  endtask

  task automatic test_stall_overrun();
    start_frame();
    service(3'b011, 30, 1'b0);
    num_vec++; if (upd_req !== 3'b100) begin $display("FAIL stall_req: got %b expected 100", upd_req); num_err++; end
    vcount = 10'd0; hcount = 10'd0; tick(); hcount = 10'd1;
    num_vec++; if (overrun !== 1'b1) begin $display("FAIL stall_ovr: got %b expected 1", overrun); num_err++; end
    num_vec++; if (busy !== 1'b1) begin $display("FAIL stall_busy: got %b expected 1", busy); num_err++; end
    num_vec++; if (err !== 3'b000) begin $display("FAIL stall_err: got %b expected 000", err); num_err++; end
    service(3'b111, 20, 1'b1);
    exp_fc = exp_fc + 8'd1;
    num_vec++; if (coll_n !== 1) begin $display("FAIL stall_coll: got %0d expected 1", coll_n); num_err++; end
    num_vec++; if (frame_cnt !== exp_fc) begin $display("FAIL stall_fcnt: got %0d expected %0d", frame_cnt, exp_fc); num_err++; end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    num_vec++; if (overrun !== 1'b0) begin $display("FAIL ovr_clear: got %b expected 0", overrun); num_err++; end
    $display("ball stall past vcount 0: overrun set, completed frame_cnt=%0d, cleared", frame_cnt);
  endtask

  task automatic test_trigger_while_busy();
    start_frame();
    service(3'b000, 3, 1'b0);
    vcount = 10'd480; hcount = 10'd0; tick(); hcount = 10'd1;
    num_vec++; if (overrun !== 1'b1) begin $display("FAIL busy_trig_ovr: got %b expected 1", overrun); num_err++; end
    num_vec++; if (upd_req !== 3'b001) begin $display("FAIL busy_trig_req: got %b expected 001", upd_req); num_err++; end
    service(3'b111, 40, 1'b1);
    exp_fc = exp_fc + 8'd1;
    num_vec++; if (frame_cnt !== exp_fc) begin $display("FAIL busy_trig_fcnt: got %0d expected %0d", frame_cnt, exp_fc); num_err++; end
    // clear and set in the same cycle: set must win
    start_frame();
    service(3'b000, 2, 1'b0);
    clr_err = 1'b1; vcount = 10'd480; hcount = 10'd0; tick(); clr_err = 1'b0; hcount = 10'd1;
    num_vec++; if (overrun !== 1'b1) begin $display("FAIL set_wins: got %b expected 1", overrun); num_err++; end
    service(3'b111, 40, 1'b1);
    exp_fc = exp_fc + 8'd1;
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    num_vec++; if (overrun !== 1'b0) begin $display("FAIL ovr_clear2: got %b expected 0", overrun); num_err++; end
    $display("trigger while busy: overrun set, sequence kept, set beats clear");
  endtask

`ifdef SCHED_TIMEOUT_EN
  task automatic test_timeout();
    start_frame();
    service(3'b101, 400, 1'b1);
    exp_fc = exp_fc + 8'd1;
    num_vec++; if (req_cyc[1] !== 200) begin $display("FAIL tmo_len: got %0d cycles expected 200", req_cyc[1]); num_err++; end
    num_vec++; if (err !== 3'b010) begin $display("FAIL tmo_err: got %b expected 010", err); num_err++; end
    num_vec++; if (frame_cnt !== exp_fc) begin $display("FAIL tmo_fcnt: got %0d expected %0d", frame_cnt, exp_fc); num_err++; end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    num_vec++; if (err !== 3'b000) begin $display("FAIL tmo_clear: got %b expected 000", err); num_err++; end
    $display("timeout: upd_req[1] high %0d cycles, frame_cnt=%0d", req_cyc[1], frame_cnt);
  endtask
`endif

  task automatic test_wrap();
    while (exp_fc != 8'd255) begin
      start_frame();
      service(3'b111, 40, 1'b1);
      exp_fc = exp_fc + 8'd1;
    end
    num_vec++; if (frame_cnt !== 8'd255) begin $display("FAIL wrap_pre: got %0d expected 255", frame_cnt); num_err++; end
    start_frame();
    service(3'b111, 40, 1'b1);
    exp_fc = exp_fc + 8'd1;
    num_vec++; if (frame_cnt !== 8'd0) begin $display("FAIL wrap: got %0d expected 0", frame_cnt); num_err++; end
    $display("frame_cnt wrap 255 -> %0d", frame_cnt);
  endtask

  task automatic test_reset_midseq();
    start_frame();
    service(3'b001, 6, 1'b0);
    num_vec++; if (upd_req !== 3'b010) begin $display("FAIL mid_pre: upd_req %b expected 010", upd_req); num_err++; end
    #2 rst_n = 1'b0;
    #1;
    num_vec++; if ({pix_en, upd_req, coll_stb, busy, frame_cnt, err, overrun} !== 17'd0) begin
      $display("FAIL mid_reset: got %h expected 0", {pix_en, upd_req, coll_stb, busy, frame_cnt, err, overrun}); num_err++; end
    tick();
    rst_n = 1'b1; exp_fc = 8'd0;
    tick();
    num_vec++; if ({pix_en, busy, upd_req} !== 5'b10000) begin
      $display("FAIL mid_idle: pix/busy/req %b expected 10000", {pix_en, busy, upd_req}); num_err++; end
    start_frame();
    service(3'b111, 40, 1'b1);
    exp_fc = exp_fc + 8'd1;
    num_vec++; if (frame_cnt !== exp_fc) begin $display("FAIL mid_after: got %0d expected %0d", frame_cnt, exp_fc); num_err++; end
    $display("reset mid-sequence: outputs cleared, next frame_cnt=%0d", frame_cnt);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_ignored_ack();
    test_game_disabled();
    test_stall_overrun();
    test_trigger_while_busy();
`ifdef SCHED_TIMEOUT_EN
    test_timeout();
`endif
    test_wrap();
    test_reset_midseq();
    $display("== %0d vectors applied, %0d miscompares ==", num_vec, num_err);
    $finish;
  end

endmodule
